// File: rtl/poly_pkg.sv
// Shared types and width helpers for the sequential polynomial evaluator.
package poly_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 32;

    // Width of a coefficient index; one spare code so out-of-range writes are representable.
    function automatic int coef_idx_w(input int degree);
        return $clog2(degree + 2);
    endfunction

    // Width of a window position index.
    function automatic int win_idx_w(input int window_size);
        return $clog2(window_size + 1);
    endfunction

endpackage

// File: rtl/poly_mac_unit.sv
// Single shared multiply-add: y = trunc(acc * x) + c, wrapping modulo 2^DATA_W.
import poly_pkg::*;

module poly_mac_unit #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] c,
    output logic signed [DATA_W-1:0] y
);

    // The low DATA_W bits of the full product equal a DATA_W-wide product,
    // so the truncated product is formed directly and the add wraps.
    assign y = acc * x + c;

endmodule

// File: rtl/poly_eval_seq.sv
// Horner-rule polynomial evaluator sharing one multiply-add across DEGREE cycles.
//
// state | meaning
// IDLE  | ready for x; coefficient writes and win_clr honoured
// MAC   | one Horner step per cycle, k counts down to 0
// OUT   | result held on y_* until y_ready
import poly_pkg::*;

module poly_eval_seq #(
    parameter int WINDOW_SIZE = 7,
    parameter int DEGREE      = 2,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               coef_wr_en,
    input  logic [coef_idx_w(DEGREE)-1:0]      coef_wr_idx,
    input  logic signed [DATA_W-1:0]           coef_wr_data,
    input  logic                               win_clr,
    input  logic                               x_valid,
    output logic                               x_ready,
    input  logic signed [DATA_W-1:0]           x_data,
    output logic                               y_valid,
    input  logic                               y_ready,
    output logic signed [DATA_W-1:0]           y_data,
    output logic [win_idx_w(WINDOW_SIZE)-1:0]  y_idx,
    output logic                               y_last,
    output logic                               busy
);

    localparam int CW = coef_idx_w(DEGREE);
    localparam int WW = win_idx_w(WINDOW_SIZE);
    localparam logic [CW-1:0] K_INIT   = (DEGREE > 0) ? CW'(DEGREE - 1) : '0;
    localparam logic [CW-1:0] C_MAX    = CW'(DEGREE);
    localparam logic [WW-1:0] POS_LAST = WW'(WINDOW_SIZE - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] coef [DEGREE+1];
    logic signed [DATA_W-1:0] x_reg;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] mac_c;
    logic signed [DATA_W-1:0] mac_y;
    logic [CW-1:0]            k;
    logic [WW-1:0]            pos;
    logic                     coef_wr_ok;

    // A write arriving with an x handshake is parked here and committed when
    // the sample completes, so the in-flight sample sees the old coefficients.
    logic                     pend_en;
    logic [CW-1:0]            pend_idx;
    logic signed [DATA_W-1:0] pend_data;

    assign coef_wr_ok = coef_wr_en && (coef_wr_idx <= C_MAX);
    assign mac_c      = coef[k];

    poly_mac_unit #(.DATA_W(DATA_W)) u_mac (
        .acc (acc),
        .x   (x_reg),
        .c   (mac_c),
        .y   (mac_y)
    );

    // Sequencer, coefficient store, window position and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_ready   <= 1'b1;
            y_valid   <= 1'b0;
            y_data    <= '0;
            y_idx     <= '0;
            y_last    <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            k         <= '0;
            x_reg     <= '0;
            pos       <= '0;
            pend_en   <= 1'b0;
            pend_idx  <= '0;
            pend_data <= '0;
            for (int j = 0; j <= DEGREE; j++) begin
                coef[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (win_clr) begin
                        pos <= '0;
                    end
                    if (x_valid) begin
                        if (coef_wr_ok) begin
                            pend_en   <= 1'b1;
                            pend_idx  <= coef_wr_idx;
                            pend_data <= coef_wr_data;
                        end
                        x_reg   <= x_data;
                        acc     <= coef[DEGREE];
                        k       <= K_INIT;
                        x_ready <= 1'b0;
                        busy    <= 1'b1;
                        if (DEGREE > 0) begin
                            state <= MAC;
                        end else begin
                            state   <= OUT;
                            y_valid <= 1'b1;
                            y_data  <= coef[DEGREE];
                            y_idx   <= win_clr ? '0 : pos;
                            y_last  <= !win_clr && (pos == POS_LAST);
                        end
                    end else if (coef_wr_ok) begin
                        coef[coef_wr_idx] <= coef_wr_data;
                    end
                end
                MAC: begin
                    acc <= mac_y;
                    k   <= k - CW'(1);
                    if (k == '0) begin
                        state   <= OUT;
                        y_valid <= 1'b1;
                        y_data  <= mac_y;
                        y_idx   <= pos;
                        y_last  <= (pos == POS_LAST);
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        state   <= IDLE;
                        y_valid <= 1'b0;
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                        pos     <= (pos == POS_LAST) ? '0 : pos + WW'(1);
                        if (pend_en) begin
                            coef[pend_idx] <= pend_data;
                            pend_en        <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval_seq.sv
// Directed bench for poly_eval_seq with DEGREE=2, WINDOW_SIZE=7, DATA_W=32.
module tb_poly_eval_seq;

    logic               clk;
    logic               rst;
    logic               coef_wr_en;
    logic [1:0]         coef_wr_idx;
    logic signed [31:0] coef_wr_data;
    logic               win_clr;
    logic               x_valid;
    logic               x_ready;
    logic signed [31:0] x_data;
    logic               y_valid;
    logic               y_ready;
    logic signed [31:0] y_data;
    logic [2:0]         y_idx;
    logic               y_last;
    logic               busy;

    int passes = 0;
    int total  = 0;

    poly_eval_seq #(.WINDOW_SIZE(7), .DEGREE(2), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_idx  (coef_wr_idx),
        .coef_wr_data (coef_wr_data),
        .win_clr      (win_clr),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .y_idx        (y_idx),
        .y_last       (y_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [1:0] idx, input logic [31:0] val);
        coef_wr_en   = 1'b1;
        coef_wr_idx  = idx;
        coef_wr_data = val;
        @(negedge clk);
        coef_wr_en   = 1'b0;
    endtask

    task automatic pulse_clr();
        win_clr = 1'b1;
        @(negedge clk);
        win_clr = 1'b0;
    endtask

    // Offer one x, wait (bounded) for the result, optionally stall y_ready, then accept it.
    task automatic run(input logic [31:0] xv, input logic [31:0] ey, input logic [2:0] eidx,
                       input logic elast, input string tag, input int stall,
                       input logic wr_with_x, input logic [31:0] wr_val);
        int n;
        check({tag, "_xrdy"}, x_ready, 1);
        x_valid = 1'b1;
        x_data  = xv;
        if (wr_with_x) begin
            coef_wr_en   = 1'b1;
            coef_wr_idx  = 2'd0;
            coef_wr_data = wr_val;
        end
        @(negedge clk);
        x_valid    = 1'b0;
        coef_wr_en = 1'b0;
        check({tag, "_busy_mac"}, {x_ready, busy}, 2'b01);
        n = 1;
        while (!y_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_data"}, y_data, ey);
        check({tag, "_idx"}, y_idx, eidx);
        check({tag, "_last"}, y_last, elast);
        for (int i = 0; i < stall; i++) begin
            if (i == 0) begin
                coef_wr_en   = 1'b1;
                coef_wr_idx  = 2'd0;
                coef_wr_data = 32'd9;
            end
            @(negedge clk);
            coef_wr_en = 1'b0;
            check({tag, "_stall_data"}, y_data, ey);
            check({tag, "_stall_idx"}, y_idx, eidx);
            check({tag, "_stall_flags"}, {y_valid, x_ready, busy}, 3'b101);
        end
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        check({tag, "_done"}, {y_valid, x_ready, busy}, 3'b010);
    endtask

    initial begin
        rst          = 1'b1;
        coef_wr_en   = 1'b0;
        coef_wr_idx  = 2'd0;
        coef_wr_data = '0;
        win_clr      = 1'b0;
        x_valid      = 1'b0;
        x_data       = '0;
        y_ready      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_flags", {x_ready, y_valid, y_last, busy}, 4'b1000);
        check("reset_data", y_data, 0);
        check("reset_idx", y_idx, 0);

        // c = {1,2,3}: y = 1 + 2x + 3x^2
        write_coef(2'd0, 32'd1);
        write_coef(2'd1, 32'd2);
        write_coef(2'd2, 32'd3);
        run(32'd2, 32'd17, 3'd0, 1'b0, "t1_x2", 0, 1'b0, '0);
        run(-32'sd1, 32'd2, 3'd1, 1'b0, "t2_xm1", 0, 1'b0, '0);
        run(32'd0, 32'd1, 3'd2, 1'b0, "t2_x0", 0, 1'b0, '0);

        // c[0]=5 written alongside the handshake: this sample still sees c[0]=1, the next sees 5.
        run(32'd2, 32'd17, 3'd3, 1'b0, "wr_with_x", 0, 1'b1, 32'd5);
        run(32'd0, 32'd5, 3'd4, 1'b0, "wr_landed", 0, 1'b0, '0);
        write_coef(2'd0, 32'd1);

        // Backpressure: 5-cycle stall with a dropped c[0]=9 write.
        run(32'd2, 32'd17, 3'd5, 1'b0, "t4_stall", 5, 1'b0, '0);
        run(32'd2, 32'd17, 3'd6, 1'b1, "t4_after", 0, 1'b0, '0);

        // c = {0,0,1}: y = x^2 modulo 2^32.  46341^2 = 2147488281 = 0x80001219.
        write_coef(2'd0, 32'd0);
        write_coef(2'd1, 32'd0);
        write_coef(2'd2, 32'd1);
        run(32'd65536, 32'd0, 3'd0, 1'b0, "t3_p65536", 0, 1'b0, '0);
        run(-32'sd65536, 32'd0, 3'd1, 1'b0, "t3_m65536", 0, 1'b0, '0);
        run(32'd46341, 32'h8000_1219, 3'd2, 1'b0, "t3_46341", 0, 1'b0, '0);

        // win_clr in IDLE restarts the window.
        pulse_clr();
        run(32'd2, 32'd4, 3'd0, 1'b0, "t5_clr_a", 0, 1'b0, '0);
        run(32'd3, 32'd9, 3'd1, 1'b0, "t5_clr_b", 0, 1'b0, '0);
        run(32'd4, 32'd16, 3'd2, 1'b0, "t5_clr_c", 0, 1'b0, '0);
        pulse_clr();
        run(32'd5, 32'd25, 3'd0, 1'b0, "t5_after_clr", 0, 1'b0, '0);

        // Eight back-to-back samples across a window wrap.
        pulse_clr();
        for (int i = 0; i < 8; i++) begin
            run(32'(i + 1), 32'((i + 1) * (i + 1)), 3'(i % 7), (i == 6), "t5_win", 0, 1'b0, '0);
        end

        // Reset during MAC discards the sample and clears coefficients and position.
        x_valid = 1'b1;
        x_data  = 32'd3;
        @(negedge clk);
        x_valid = 1'b0;
        check("t6_in_mac", {x_ready, busy}, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_flags", {x_ready, y_valid, y_last, busy}, 4'b1000);
        check("t6_idx", y_idx, 0);
        check("t6_data", y_data, 0);
        run(32'd5, 32'd0, 3'd0, 1'b0, "t6_post", 0, 1'b0, '0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
